// File: rtl/endeavour_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// endeavour_led_pwm_driver
//   LED PWM output stage that sits behind the endeavour FMC LED controller
//   register file. The four slave registers (control, duty, prescale, blink)
//   are copied into shadow registers only at safe points: immediately when
//   the block is idle, otherwise at the next PWM period boundary. This means
//   the LED waveform never shows a partial period.
//
//   Optional build macro: LED_GAMMA_EN
//     When defined, each duty value is squared and scaled (d*d >> 8) once, at
//     shadow load. A duty of 255 still means fully on.
//
//   Ports
//     ACLK, ARESETN   clock, asynchronous active-low reset
//     ctrl_reg        [NUM_LED-1:0] LED enable, [8+NUM_LED-1:8] blink enable
//     duty_reg        8-bit duty per LED, LED i at [8i+7:8i]
//     prescale_reg    [PRESCALE_W-1:0] PWM tick divider (tick every P+1 clks)
//     blink_reg       [PRESCALE_W-1:0] blink half-period in PWM periods
//     cfg_update      one-cycle pulse on any register write
//     led_out         LED drive, active high, registered
//     period_strobe   one-cycle pulse after each PWM period wrap
//     update_pending  high while a shadow load waits for a period boundary
// ---------------------------------------------------------------------------

// Per-LED slice: duty/enable shadows plus the registered output compare.
module endeavour_led_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,        // copy shadow inputs this edge
  input  logic                i_active,      // FSM is not IDLE
  input  logic                i_go_idle,     // FSM enters IDLE this edge
  input  logic                i_en,
  input  logic                i_blink_en,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_blink_phase,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = {PWM_BITS{1'b1}};

  logic                r_en;
  logic                r_blink_en;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic [PWM_BITS-1:0] w_duty_eff;
  logic                w_on;

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq;
  logic                  w_unused;
  assign w_sq       = {{PWM_BITS{1'b0}}, i_duty} * {{PWM_BITS{1'b0}}, i_duty};
  // Full-scale must stay full-scale; the square alone would give 254.
  assign w_duty_eff = (i_duty == DUTY_FULL) ? DUTY_FULL : w_sq[2*PWM_BITS-1:PWM_BITS];
  assign w_unused   = ^w_sq[PWM_BITS-1:0];
`else
  assign w_duty_eff = i_duty;
`endif

  assign w_on = r_en
              & ((r_duty == DUTY_FULL) | (i_pwm_cnt < r_duty))
              & (~r_blink_en | i_blink_phase);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en       <= 1'b0;
      r_blink_en <= 1'b0;
      r_duty     <= '0;
    end else if (i_load) begin
      r_en       <= i_en;
      r_blink_en <= i_blink_en;
      r_duty     <= w_duty_eff;
    end
  end

  // Output uses the shadows as they were before this edge, so a load at the
  // boundary edge does not disturb the last cycle of the old period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_led <= 1'b0;
    else if (!i_active || i_go_idle)  r_led <= 1'b0;
    else                              r_led <= w_on;
  end

  assign o_led = r_led;

endmodule

module endeavour_led_pwm_driver #(
  parameter int NUM_LED    = 4,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        ctrl_reg,
  input  logic [31:0]        duty_reg,
  input  logic [31:0]        prescale_reg,
  input  logic [31:0]        blink_reg,
  input  logic               cfg_update,
  output logic [NUM_LED-1:0] led_out,
  output logic               period_strobe,
  output logic               update_pending
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [PWM_BITS-1:0]   PWM_ONE = 1;
  localparam logic [PWM_BITS-1:0]   PWM_MAX = {PWM_BITS{1'b1}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

  logic [1:0]            r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_blink;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PRESCALE_W-1:0] r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_period_strobe;
  logic                  r_update_pending;

  logic [1:0]            w_next;
  logic                  w_active;
  logic                  w_tick;
  logic                  w_bound;
  logic                  w_load;
  logic                  w_go_idle;
  logic                  w_any_en_in;
  logic [NUM_LED-1:0]    w_led;
  logic                  w_unused;

  assign w_active    = (r_state != ST_IDLE);
  assign w_tick      = w_active && (r_pre_cnt == r_prescale);
  assign w_bound     = w_tick && (r_pwm_cnt == PWM_MAX);
  assign w_any_en_in = |ctrl_reg[NUM_LED-1:0];
  assign w_load      = ((r_state == ST_IDLE) && cfg_update) ||
                       ((r_state == ST_PEND) && w_bound);
  assign w_go_idle   = w_active && (w_next == ST_IDLE);

  // Register bits outside the used fields are intentionally ignored.
  assign w_unused = ^{ctrl_reg, duty_reg, prescale_reg, blink_reg};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (cfg_update) w_next = w_any_en_in ? ST_RUN : ST_IDLE;
      ST_RUN:  if (cfg_update) w_next = ST_PEND;
      ST_PEND: begin
        // A write landing on the boundary still loads now, but its own
        // values may differ from what got sampled, so wait one more period.
        if (w_bound) begin
          if (cfg_update) w_next = ST_PEND;
          else            w_next = w_any_en_in ? ST_RUN : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state          <= ST_IDLE;
      r_update_pending <= 1'b0;
      r_period_strobe  <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_update_pending <= (w_next == ST_PEND);
      r_period_strobe  <= w_bound;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_prescale <= '0;
      r_blink    <= '0;
    end else if (w_load) begin
      r_prescale <= prescale_reg[PRESCALE_W-1:0];
      r_blink    <= blink_reg[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_next == ST_IDLE) begin
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_tick)        r_pre_cnt <= '0;
      else if (w_active) r_pre_cnt <= r_pre_cnt + PRE_ONE;

      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_ONE;

      // A load restarts the blink pattern in its on phase.
      if (w_load) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b1;
      end else if (w_bound && (r_blink != '0)) begin
        if (r_blink_cnt == r_blink - PRE_ONE) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt   <= r_blink_cnt + PRE_ONE;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_lane
    endeavour_led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .i_clk         (ACLK),
      .i_rst_n       (ARESETN),
      .i_load        (w_load),
      .i_active      (w_active),
      .i_go_idle     (w_go_idle),
      .i_en          (ctrl_reg[i]),
      .i_blink_en    (ctrl_reg[8+i]),
      .i_duty        (duty_reg[8*i +: PWM_BITS]),
      .i_pwm_cnt     (r_pwm_cnt),
      .i_blink_phase (r_blink_phase),
      .o_led         (w_led[i])
    );
  end

  assign led_out        = w_led;
  assign period_strobe  = r_period_strobe;
  assign update_pending = r_update_pending;

endmodule
